// File: rtl/lamp_pkg.sv
// Shared types for the tail-lamp sequencing logic: request modes, FSM states
// and the request-priority decode.
package lamp_pkg;

  localparam int CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {NONE, LEFT, RIGHT, BOTH} mode_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DARK} state_t;

  // Hazard, or both turn requests together, wins over a single side.
  function automatic mode_t decode_req(input logic left_req, input logic right_req,
                                       input logic hazard_req);
    if (hazard_req || (left_req && right_req)) return BOTH;
    else if (left_req) return LEFT;
    else if (right_req) return RIGHT;
    else return NONE;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/turn_sweep_sequencer.sv
// Sequential turn-signal controller: lights the inner k segments step by step,
// then a dark gap, repeating while a request is held. All outputs registered.
module turn_sweep_sequencer
  import lamp_pkg::*;
#(
  parameter int SEGS        = 3,
  parameter int STEP_CYCLES = 15_000_000,
  parameter int OFF_CYCLES  = 30_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            left_req,
  input  logic            right_req,
  input  logic            hazard_req,
  input  logic            brake,
  output logic [SEGS-1:0] left_lamps,
  output logic [SEGS-1:0] right_lamps,
  output logic            cycle_start,
  output logic            busy
);

  localparam int MAX_CYC = (STEP_CYCLES > OFF_CYCLES) ? STEP_CYCLES : OFF_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int KW      = $clog2(SEGS + 1);
  localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(SEGS);

  state_t          state_reg, state_next;
  mode_t           mode_reg, mode_next;
  logic [KW-1:0]   k_reg, k_next;
  mode_t           req_mode;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            done;
  logic            cycle_start_next;
  logic [SEGS-1:0] sweep_pat;
  logic [SEGS-1:0] brake_pat;
  logic [SEGS-1:0] left_next, right_next;

  tick_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  assign req_mode = decode_req(left_req, right_req, hazard_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mode_reg    <= NONE;
      k_reg       <= '0;
      left_lamps  <= '0;
      right_lamps <= '0;
      cycle_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      k_reg       <= k_next;
      left_lamps  <= left_next;
      right_lamps <= right_next;
      cycle_start <= cycle_start_next;
      busy        <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next       = state_reg;
    mode_next        = mode_reg;
    k_next           = k_reg;
    load             = 1'b0;
    load_val         = STEP_LOAD;
    cycle_start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_mode != NONE) begin
          state_next       = SWEEP;
          mode_next        = req_mode;
          k_next           = KW'(1);
          load             = 1'b1;
          cycle_start_next = 1'b1;
        end
      end
      SWEEP: begin
        if (done) begin
          load = 1'b1;
          if (k_reg < K_LAST) begin
            k_next = k_reg + 1'b1;
          end else begin
            state_next = DARK;
            k_next     = '0;
            load_val   = OFF_LOAD;
          end
        end
      end
      DARK: begin
        // The only point where the mode may change, so a pattern is never cut short.
        if (done) begin
          if (req_mode != NONE) begin
            state_next       = SWEEP;
            mode_next        = req_mode;
            k_next           = KW'(1);
            load             = 1'b1;
            cycle_start_next = 1'b1;
          end else begin
            state_next = IDLE;
            mode_next  = NONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        mode_next  = NONE;
        k_next     = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < SEGS; gi++) begin : g_pat
    assign sweep_pat[gi] = (state_next == SWEEP) && (k_next > KW'(gi));
  end

  assign brake_pat = {SEGS{brake}};

  always_comb begin
    left_next  = brake_pat;
    right_next = brake_pat;
    case (mode_next)
      LEFT:    left_next = sweep_pat;
      RIGHT:   right_next = sweep_pat;
      BOTH: begin
        left_next  = sweep_pat;
        right_next = sweep_pat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_turn_sweep_sequencer.sv
// Directed bench for turn_sweep_sequencer with SEGS=3, STEP_CYCLES=4, OFF_CYCLES=6.
module tb_turn_sweep_sequencer;

  logic       clk;
  logic       rst;
  logic       left_req, right_req, hazard_req, brake;
  logic [2:0] left_lamps, right_lamps;
  logic       cycle_start, busy;

  int checks = 0;
  int errors = 0;

  turn_sweep_sequencer #(
    .SEGS        (3),
    .STEP_CYCLES (4),
    .OFF_CYCLES  (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .left_req    (left_req),
    .right_req   (right_req),
    .hazard_req  (hazard_req),
    .brake       (brake),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps),
    .cycle_start (cycle_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] exp_l, input logic [2:0] exp_r,
                         input logic exp_cs, input logic exp_busy);
    chk({tag, ".left"},  {5'b0, left_lamps},  {5'b0, exp_l});
    chk({tag, ".right"}, {5'b0, right_lamps}, {5'b0, exp_r});
    chk({tag, ".cs"},    {7'b0, cycle_start}, {7'b0, exp_cs});
    chk({tag, ".busy"},  {7'b0, busy},        {7'b0, exp_busy});
  endtask

  // Hand table of one 18-clk period: 4x001, 4x011, 4x111, 6x000.
  function automatic logic [2:0] pat(input int c);
    int p;
    p = (c - 1) % 18;
    if (p < 4)       return 3'b001;
    else if (p < 8)  return 3'b011;
    else if (p < 12) return 3'b111;
    else             return 3'b000;
  endfunction

  function automatic logic cs_at(input int c);
    return ((c - 1) % 18) == 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    tick();
    tick();
    chk_all("reset", 3'b000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle", 3'b000, 3'b000, 1'b0, 1'b0);
    brake = 1'b1;
    tick();
    chk_all("idle_brake", 3'b111, 3'b111, 1'b0, 1'b0);
    $display("step idle: reset and brake-only checked");

    // 1: left sweep, two full periods
    do_reset();
    left_req = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      chk_all("s1", pat(c), 3'b000, cs_at(c), 1'b1);
    end
    $display("step 1: left sweep two periods");

    // 2: right sweep with brake, then brake released
    do_reset();
    right_req = 1'b1; brake = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk_all("s2", 3'b111, pat(c), cs_at(c), 1'b1);
    end
    brake = 1'b0;
    tick();
    chk_all("s2_release", 3'b000, 3'b001, 1'b1, 1'b1);
    $display("step 2: right sweep with brake");

    // 3: hazard with brake, both sides in phase
    do_reset();
    hazard_req = 1'b1; brake = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk_all("s3", pat(c), pat(c), cs_at(c), 1'b1);
    end
    $display("step 3: hazard with brake");

    // 4: hazard raised in SWEEP(2) of a left cycle
    do_reset();
    left_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c < 19) chk_all("s4_left", pat(c), 3'b000, cs_at(c), 1'b1);
      else        chk_all("s4_both", pat(c), pat(c), cs_at(c), 1'b1);
      if (c == 5) hazard_req = 1'b1;
    end
    $display("step 4: hazard mid-sweep waits for cycle boundary");

    // 5: request held 5 clks then dropped
    do_reset();
    left_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c < 19) chk_all("s5_run", pat(c), 3'b000, cs_at(c), 1'b1);
      else        chk_all("s5_idle", 3'b000, 3'b000, 1'b0, 1'b0);
      if (c == 5) left_req = 1'b0;
    end
    $display("step 5: dropped request completes cycle then idles");

    // 6: rst during SWEEP(3) of BOTH, requests kept
    do_reset();
    hazard_req = 1'b1;
    for (int c = 1; c <= 9; c++) tick();
    chk_all("s6_sweep3", 3'b111, 3'b111, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk_all("s6_rst", 3'b000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("s6_restart", 3'b001, 3'b001, 1'b1, 1'b1);
    $display("step 6: reset mid-sweep and restart");

    // 7: request drops exactly as the dark gap ends
    do_reset();
    right_req = 1'b1;
    for (int c = 1; c <= 18; c++) tick();
    chk_all("s7_dark_end", 3'b000, 3'b000, 1'b0, 1'b1);
    right_req = 1'b0;
    tick();
    chk_all("s7_idle", 3'b000, 3'b000, 1'b0, 1'b0);
    $display("step 7: drop at dark end returns to idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
